// File: rtl/cfg_descriptor_reader.sv
// -----------------------------------------------------------------------------
// cfg_descriptor_reader
//
// Serves the flattened configuration descriptor over a valid/ready
// request/response port. The descriptor is snapshotted when a request is
// accepted, so every beat of a transaction comes from one coherent copy.
//
// Two transaction types:
//   - single read: one beat holding data word req_idx_i, or zero with
//                  rsp_err_o set when the index is out of range.
//   - burst:       header {MAGIC, NUM_WORDS[15:0]}, every data word in order,
//                  then the bitwise inverse of the 32-bit sum of the header
//                  and all data words (NUM_WORDS+2 beats in total).
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   cfg_words_i  descriptor, word k at bits [32k+31:32k]
//   req_valid_i  request valid
//   req_ready_o  request ready (high only when idle)
//   req_burst_i  1 = full-descriptor burst, 0 = single read
//   req_idx_i    data word index for a single read
//   rsp_valid_o  response valid
//   rsp_ready_i  response ready
//   rsp_data_o   response word
//   rsp_last_o   final beat of the transaction
//   rsp_err_o    single-read index out of range
//   busy_o       transaction in progress
// -----------------------------------------------------------------------------
module cfg_descriptor_reader #(
  parameter int unsigned NUM_WORDS = 16,
  parameter logic [15:0] MAGIC     = 16'hC6A6,
  parameter int unsigned IDX_W     = $clog2(NUM_WORDS) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_WORDS*32-1:0]  cfg_words_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_burst_i,
  input  logic [IDX_W-1:0]         req_idx_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_last_o,
  output logic                     rsp_err_o,
  output logic                     busy_o
);

  localparam logic [31:0] HEADER = {MAGIC, 16'(NUM_WORDS)};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SINGLE = 3'd1,
    S_HDR    = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [NUM_WORDS*32-1:0]   r_snap;
  logic [31:0]               r_acc;
  logic [IDX_W-1:0]          r_cnt;
  logic                      r_rsp_valid;
  logic [31:0]               r_rsp_data;
  logic                      r_rsp_last;
  logic                      r_rsp_err;

  logic                      w_hs;
  logic [31:0]               w_sum;

  // Selects descriptor word k; out-of-range indices read as zero.
  function automatic logic [31:0] word_at(input logic [NUM_WORDS*32-1:0] words,
                                          input int unsigned k);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (k < NUM_WORDS) begin
      w = words[k*32 +: 32];
    end else begin
      w = 32'h0000_0000;
    end
    return w;
  endfunction

  assign w_hs  = r_rsp_valid & rsp_ready_i;
  // The beat on the bus is the data word currently being folded into the sum.
  assign w_sum = r_acc + r_rsp_data;

  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_last_o  = r_rsp_last;
  assign rsp_err_o   = r_rsp_err;

  // Transaction FSM; each beat is registered one cycle ahead of its handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_acc       <= 32'h0000_0000;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0000_0000;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_snap      <= cfg_words_i;
            r_rsp_valid <= 1'b1;
            if (req_burst_i) begin
              r_state    <= S_HDR;
              r_rsp_data <= HEADER;
              r_rsp_last <= 1'b0;
              r_rsp_err  <= 1'b0;
            end else begin
              // Single-read beat comes straight from the input, which equals
              // the snapshot being captured in this same cycle.
              r_state    <= S_SINGLE;
              r_rsp_data <= word_at(cfg_words_i, 32'(req_idx_i));
              r_rsp_last <= 1'b1;
              r_rsp_err  <= (32'(req_idx_i) >= NUM_WORDS);
            end
          end
        end
        S_SINGLE: begin
          if (w_hs) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        S_HDR: begin
          if (w_hs) begin
            r_state    <= S_DATA;
            r_acc      <= HEADER;
            r_cnt      <= '0;
            r_rsp_data <= word_at(r_snap, 32'd0);
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            if (32'(r_cnt) == NUM_WORDS - 32'd1) begin
              r_state    <= S_CSUM;
              r_rsp_data <= ~w_sum;
              r_rsp_last <= 1'b1;
            end else begin
              r_rsp_data <= word_at(r_snap, 32'(r_cnt) + 32'd1);
            end
          end
        end
        S_CSUM: begin
          if (w_hs) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_last  <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_descriptor_reader.sv
// -----------------------------------------------------------------------------
// tb_cfg_descriptor_reader
//
// Directed scenarios plus randomized transactions. Expected beats are derived
// from the descriptor contents at request time with plain arithmetic; every
// presented beat is compared while the bench drives random backpressure.
// -----------------------------------------------------------------------------
module tb_cfg_descriptor_reader;

  localparam int unsigned NW = 4;
  localparam logic [15:0] MG = 16'hC6A6;
  localparam int unsigned IW = $clog2(NW) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NW*32-1:0]  cfg_words_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_burst_i;
  logic [IW-1:0]     req_idx_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_data_o;
  logic              rsp_last_o;
  logic              rsp_err_o;
  logic              busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_data[$];
  logic        exp_err[$];

  cfg_descriptor_reader #(
    .NUM_WORDS (NW),
    .MAGIC     (MG)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_words_i (cfg_words_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_burst_i (req_burst_i),
    .req_idx_i   (req_idx_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_last_o  (rsp_last_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Counts one comparison and reports it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the full beat list for one transaction, from the descriptor.
  function automatic void build_exp(input logic [NW*32-1:0] w, input bit burst, input int idx);
    logic [31:0] sum;
    logic [31:0] word;
    exp_data.delete();
    exp_err.delete();
    if (!burst) begin
      if (idx < int'(NW)) begin
        exp_data.push_back(w[idx*32 +: 32]);
        exp_err.push_back(1'b0);
      end else begin
        exp_data.push_back(32'h0000_0000);
        exp_err.push_back(1'b1);
      end
    end else begin
      sum = {MG, 16'(NW)};
      exp_data.push_back(sum);
      exp_err.push_back(1'b0);
      for (int k = 0; k < int'(NW); k++) begin
        word = w[k*32 +: 32];
        exp_data.push_back(word);
        exp_err.push_back(1'b0);
        sum = sum + word;
      end
      exp_data.push_back(~sum);
      exp_err.push_back(1'b0);
    end
  endfunction

  // One transaction. rmode: 0 ready held high, 1 toggle from 0, 2 random.
  // abort_at >= 0 asserts reset while that beat index is presented.
  task automatic run_txn(input bit burst, input int idx, input int rmode,
                         input bit corrupt, input bit hold, input int abort_at);
    int          b;
    int          cyc;
    int          len;
    bit          stalled;
    bit          tog;
    bit          r;
    bit          aborted;
    logic [31:0] held;
    @(negedge clk_i);
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    build_exp(cfg_words_i, burst, idx);
    len         = exp_data.size();
    req_valid_i = 1'b1;
    req_burst_i = burst;
    req_idx_i   = IW'(idx);
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    if (!hold) req_valid_i = 1'b0;
    if (corrupt) cfg_words_i[31:0] = 32'hFFFF_FFFF;
    b = 0; cyc = 0; stalled = 1'b0; tog = 1'b0; aborted = 1'b0; held = 32'h0;
    while (b < len && cyc < 200) begin
      check("rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("busy", 32'(busy_o), 32'd1);
      check("req_ready_busy", 32'(req_ready_o), 32'd0);
      check("rsp_data", rsp_data_o, exp_data[b]);
      check("rsp_last", 32'(rsp_last_o), 32'(b == len - 1));
      check("rsp_err", 32'(rsp_err_o), 32'(exp_err[b]));
      if (stalled) check("stall_stable", rsp_data_o, held);
      if (abort_at == b) begin
        rst_i       = 1'b1;
        rsp_ready_i = 1'b0;
        aborted     = 1'b1;
        break;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      rsp_ready_i = r;
      stalled     = !r;
      held        = rsp_data_o;
      @(negedge clk_i);
      if (r) b++;
      cyc++;
    end
    if (aborted) begin
      @(negedge clk_i);
      rst_i = 1'b0;
      check("abort_valid", 32'(rsp_valid_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_ready", 32'(req_ready_o), 32'd1);
    end else begin
      if (cyc >= 200) check("timeout", 32'd0, 32'd1);
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b0;
      check("end_valid", 32'(rsp_valid_o), 32'd0);
      check("end_busy", 32'(busy_o), 32'd0);
      check("end_ready", 32'(req_ready_o), 32'd1);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_burst_i = 1'b0;
    req_idx_i   = '0;
    rsp_ready_i = 1'b0;
    cfg_words_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_data", rsp_data_o, 32'h0);
    check("rst_last", 32'(rsp_last_o), 32'd0);
    check("rst_err", 32'(rsp_err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;

    // Known-answer burst from the fixed descriptor.
    build_exp(cfg_words_i, 1'b1, 0);
    check("kat_hdr", exp_data[0], 32'hC6A6_0004);
    check("kat_csum", exp_data[5], 32'h8EAF_5551);

    run_txn(1'b0, 2, 0, 1'b0, 1'b0, -1);   // single in range
    run_txn(1'b0, 5, 0, 1'b0, 1'b0, -1);   // single out of range
    run_txn(1'b0, 0, 0, 1'b0, 1'b0, -1);   // next request normal
    run_txn(1'b0, 3, 0, 1'b0, 1'b0, -1);   // last valid index
    run_txn(1'b0, 4, 0, 1'b0, 1'b0, -1);   // first invalid index
    run_txn(1'b1, 0, 0, 1'b0, 1'b0, -1);   // burst, no stall
    run_txn(1'b1, 0, 1, 1'b1, 1'b0, -1);   // burst, toggled ready, input changed
    cfg_words_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    run_txn(1'b1, 0, 0, 1'b0, 1'b0, 3);    // reset during word 2
    run_txn(1'b1, 0, 0, 1'b0, 1'b0, -1);   // full burst after reset
    run_txn(1'b1, 0, 2, 1'b0, 1'b1, -1);   // request held high while busy
    run_txn(1'b0, 1, 2, 1'b0, 1'b1, -1);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < int'(NW); k++) cfg_words_i[k*32 +: 32] = $urandom;
      run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
